// File: rtl/tiro_pkg.sv
// Shared types and constants for the enemy projectile controller.
package tiro_pkg;

    localparam int W_PIX = 10;

    localparam logic [1:0] EJ_RODANDO = 2'd1;
    localparam logic [1:0] EJ_VENCEU  = 2'd2;
    localparam logic [1:0] EJ_PERDEU  = 2'd3;

    typedef enum logic [2:0] {
        PARADO,
        CORRENDO,
        ATINGIDO,
        MORTO,
        INVULNERAVEL
    } estado_t;

    // 1-D interval overlap of [a,a+aw) and [b,b+bw); 11-bit sums keep edges from wrapping.
    function automatic logic sobrepoe(
        input logic [W_PIX-1:0] a,
        input logic [W_PIX-1:0] aw,
        input logic [W_PIX-1:0] b,
        input logic [W_PIX-1:0] bw
    );
        logic [W_PIX:0] a_fim;
        logic [W_PIX:0] b_fim;
        a_fim = {1'b0, a} + {1'b0, aw};
        b_fim = {1'b0, b} + {1'b0, bw};
        return ({1'b0, a} < b_fim) && ({1'b0, b} < a_fim);
    endfunction

endpackage

// File: rtl/tiro_slot.sv
// One enemy projectile register: load on spawn, fall by VEL per step,
// free itself at the screen bottom, and report overlap with the player.
module tiro_slot
    import tiro_pkg::*;
#(
    parameter logic [W_PIX-1:0] TIRO_W      = 10'd2,
    parameter logic [W_PIX-1:0] TIRO_H      = 10'd8,
    parameter logic [W_PIX-1:0] VEL         = 10'd4,
    parameter logic [W_PIX-1:0] ALTURA_TELA = 10'd480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             step,
    input  logic [W_PIX-1:0] load_x,
    input  logic [W_PIX-1:0] load_y,
    input  logic [W_PIX-1:0] jogador_x,
    input  logic [W_PIX-1:0] jogador_y,
    input  logic [W_PIX-1:0] jogador_w,
    input  logic [W_PIX-1:0] jogador_h,
    output logic             ativo,
    output logic [W_PIX-1:0] x,
    output logic [W_PIX-1:0] y,
    output logic             hit
);

    logic             ativo_reg;
    logic [W_PIX-1:0] x_reg;
    logic [W_PIX-1:0] y_reg;
    logic [W_PIX:0]   y_passo;

    assign y_passo = {1'b0, y_reg} + {1'b0, VEL};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ativo_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else if (clr) begin
            ativo_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else if (load) begin
            ativo_reg <= 1'b1;
            x_reg     <= load_x;
            y_reg     <= load_y;
        end else if (step && ativo_reg) begin
            // A projectile leaving the screen is freed; its last y is kept.
            if (y_passo >= {1'b0, ALTURA_TELA}) begin
                ativo_reg <= 1'b0;
            end else begin
                y_reg <= y_passo[W_PIX-1:0];
            end
        end
    end

    assign ativo = ativo_reg;
    assign x     = x_reg;
    assign y     = y_reg;
    assign hit   = ativo_reg
                 && sobrepoe(x_reg, TIRO_W, jogador_x, jogador_w)
                 && sobrepoe(y_reg, TIRO_H, jogador_y, jogador_h);

endmodule

// File: rtl/enemy_tiro_ctrl.sv
// Enemy projectile controller: spawns shots under the selected invader, moves
// them, detects player hits. Optional lives/invulnerability via ENEMY_TIRO_VIDAS_EN.
module enemy_tiro_ctrl
    import tiro_pkg::*;
#(
    parameter int               LINHAS      = 4,
    parameter int               COLUNAS     = 8,
    parameter int               N_TIROS     = 4,
    parameter logic [W_PIX-1:0] ESP_X       = 10'd40,
    parameter logic [W_PIX-1:0] ESP_Y       = 10'd32,
    parameter logic [W_PIX-1:0] ENEMY_W     = 10'd24,
    parameter logic [W_PIX-1:0] ENEMY_H     = 10'd16,
    parameter logic [W_PIX-1:0] TIRO_W      = 10'd2,
    parameter logic [W_PIX-1:0] TIRO_H      = 10'd8,
    parameter logic [19:0]      PASSO       = 20'd250000,
    parameter logic [W_PIX-1:0] VEL         = 10'd4,
    parameter logic [W_PIX-1:0] ALTURA_TELA = 10'd480
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart,
    input  logic [1:0]               estado_jogo,
    input  logic                     tiro_valid,
    input  logic [5:0]               ID_enemy_tiro_X,
    input  logic [5:0]               ID_enemy_tiro_Y,
    input  logic [W_PIX-1:0]         formacao_x,
    input  logic [W_PIX-1:0]         formacao_y,
    input  logic [W_PIX-1:0]         jogador_x,
    input  logic [W_PIX-1:0]         jogador_y,
    input  logic [W_PIX-1:0]         jogador_w,
    input  logic [W_PIX-1:0]         jogador_h,
    output logic                     jogador_vivo,
    output logic [N_TIROS-1:0]       tiro_ativo,
    output logic [W_PIX*N_TIROS-1:0] tiro_x,
    output logic [W_PIX*N_TIROS-1:0] tiro_y
`ifdef ENEMY_TIRO_VIDAS_EN
    ,
    output logic [1:0]               vidas
`endif
);

    localparam int unsigned N_INV = LINHAS * COLUNAS;

    estado_t             state_reg;
    estado_t             state_next;
    logic                vivo_reg;
    logic                vivo_next;
    logic [19:0]         cnt_reg;
    logic                running;
    logic                step;
    logic                clr_all;
    logic                spawn_ok;
    logic                hit_any;
    logic                idx_ok;
    logic [5:0]          col;
    logic [W_PIX-1:0]    spawn_x;
    logic [W_PIX-1:0]    spawn_y;
    logic [N_TIROS-1:0]  slot_hit;
    logic [N_TIROS-1:0]  free_onehot;
    logic [N_TIROS-1:0]  load_vec;

    assign idx_ok  = 32'(ID_enemy_tiro_X) < N_INV;
    assign col     = ID_enemy_tiro_X - 6'(32'(ID_enemy_tiro_Y) * COLUNAS);
    assign spawn_x = formacao_x + W_PIX'(col) * ESP_X + (ENEMY_W >> 1);
    assign spawn_y = formacao_y + W_PIX'(ID_enemy_tiro_Y) * ESP_Y + ENEMY_H;

    assign running = (state_reg == CORRENDO) || (state_reg == INVULNERAVEL);
    assign step    = running && (cnt_reg == PASSO - 20'd1);
    assign hit_any = (state_reg == CORRENDO) && (|slot_hit);

    // Lowest-index free slot, taken from registered occupancy so a slot freed
    // by movement on this edge is not reused until the next one.
    always_comb begin
        free_onehot = '0;
        for (int i = N_TIROS - 1; i >= 0; i--) begin
            if (!tiro_ativo[i]) begin
                free_onehot    = '0;
                free_onehot[i] = 1'b1;
            end
        end
    end

    assign load_vec = spawn_ok ? free_onehot : '0;

`ifdef ENEMY_TIRO_VIDAS_EN
    localparam logic [31:0] INV_CICLOS = 32'd120 * 32'(PASSO);

    logic [1:0]  vidas_reg;
    logic [1:0]  vidas_next;
    logic [31:0] inv_cnt_reg;
    logic        inv_fim;

    assign inv_fim = inv_cnt_reg == INV_CICLOS - 32'd1;
    assign vidas   = vidas_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vidas_reg   <= 2'd3;
            inv_cnt_reg <= '0;
        end else begin
            vidas_reg   <= vidas_next;
            inv_cnt_reg <= (!restart && state_reg == INVULNERAVEL) ? inv_cnt_reg + 32'd1 : '0;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        vivo_next  = vivo_reg;
        clr_all    = 1'b0;
        spawn_ok   = 1'b0;
`ifdef ENEMY_TIRO_VIDAS_EN
        vidas_next = vidas_reg;
`endif
        if (restart) begin
            state_next = PARADO;
            vivo_next  = 1'b1;
            clr_all    = 1'b1;
`ifdef ENEMY_TIRO_VIDAS_EN
            vidas_next = 2'd3;
`endif
        end else begin
            unique case (state_reg)
                PARADO: begin
                    if (estado_jogo == EJ_RODANDO) state_next = CORRENDO;
                end
                CORRENDO: begin
                    if (hit_any) begin
                        clr_all = 1'b1;
`ifdef ENEMY_TIRO_VIDAS_EN
                        if (vidas_reg > 2'd1) begin
                            vidas_next = vidas_reg - 2'd1;
                            state_next = INVULNERAVEL;
                        end else begin
                            vidas_next = 2'd0;
                            vivo_next  = 1'b0;
                            state_next = ATINGIDO;
                        end
`else
                        vivo_next  = 1'b0;
                        state_next = ATINGIDO;
`endif
                    end else begin
                        spawn_ok = tiro_valid && idx_ok;
                        if (estado_jogo != EJ_RODANDO) state_next = PARADO;
                    end
                end
                ATINGIDO: begin
                    clr_all    = 1'b1;
                    vivo_next  = 1'b0;
                    state_next = MORTO;
                end
                MORTO: begin
                    vivo_next = 1'b0;
                end
`ifdef ENEMY_TIRO_VIDAS_EN
                INVULNERAVEL: begin
                    spawn_ok = tiro_valid && idx_ok;
                    if (inv_fim) state_next = CORRENDO;
                end
`endif
                default: begin
                    state_next = PARADO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= PARADO;
            vivo_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            vivo_reg  <= vivo_next;
            if (restart) begin
                cnt_reg <= '0;
            end else if (running) begin
                cnt_reg <= step ? '0 : cnt_reg + 20'd1;
            end
        end
    end

    assign jogador_vivo = vivo_reg;

    for (genvar gi = 0; gi < N_TIROS; gi++) begin : g_slot
        tiro_slot #(
            .TIRO_W      (TIRO_W),
            .TIRO_H      (TIRO_H),
            .VEL         (VEL),
            .ALTURA_TELA (ALTURA_TELA)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .clr       (clr_all),
            .load      (load_vec[gi]),
            .step      (step),
            .load_x    (spawn_x),
            .load_y    (spawn_y),
            .jogador_x (jogador_x),
            .jogador_y (jogador_y),
            .jogador_w (jogador_w),
            .jogador_h (jogador_h),
            .ativo     (tiro_ativo[gi]),
            .x         (tiro_x[gi*W_PIX +: W_PIX]),
            .y         (tiro_y[gi*W_PIX +: W_PIX]),
            .hit       (slot_hit[gi])
        );
    end

endmodule
